// File: rtl/cordic_sequencer.sv
// Command sequencer for the shared iterative CORDIC datapath: latches one command,
// issues a load cycle plus ITERATIONS micro-steps, then captures and presents the result.
module cordic_sequencer #(
  parameter int ITERATIONS = 16,
  parameter int IDX_W      = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       operation_in,
  input  logic [31:0]      angle_in,
  input  logic [21:0]      x_in,
  input  logic [21:0]      y_in,
  input  logic             abort,
  output logic             cmd_ready,
  output logic             busy,
  output logic             dp_load,
  output logic             dp_step,
  output logic [IDX_W-1:0] dp_iter,
  output logic [1:0]       dp_mode,
  output logic [31:0]      dp_angle,
  output logic [21:0]      dp_x,
  output logic [21:0]      dp_y,
  input  logic [21:0]      dp_x_res,
  input  logic [21:0]      dp_y_res,
  input  logic [31:0]      dp_z_res,
  output logic [21:0]      result_x,
  output logic [21:0]      result_y,
  output logic [31:0]      result_z,
  output logic             result_valid,
  output logic             error
);

  typedef enum logic [2:0] {S_IDLE, S_ERR, S_LOAD, S_ITER, S_CAPTURE, S_DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ITERATIONS - 1);
  localparam logic [1:0]       OP_RSVD  = 2'b11;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] iter_cnt;
  logic             accept;

  assign accept = (state == S_IDLE) && start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = (operation_in == OP_RSVD) ? S_ERR : S_LOAD;
      S_ERR:     state_nxt = S_IDLE;
      S_LOAD:    state_nxt = abort ? S_IDLE : S_ITER;
      S_ITER:    if (abort)                    state_nxt = S_IDLE;
                 else if (iter_cnt == LAST_IDX) state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = abort ? S_IDLE : S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Operands are held across IDLE so the datapath inputs only move on an accepted command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dp_mode  <= '0;
      dp_angle <= '0;
      dp_x     <= '0;
      dp_y     <= '0;
    end else if (accept) begin
      dp_mode  <= operation_in;
      dp_angle <= angle_in;
      dp_x     <= x_in;
      dp_y     <= y_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 iter_cnt <= '0;
    else if (state == S_ITER)  iter_cnt <= iter_cnt + 1'b1;
    else                       iter_cnt <= '0;
  end

  // An abort during CAPTURE must leave the previous results untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_x <= '0;
      result_y <= '0;
      result_z <= '0;
    end else if (state == S_CAPTURE && !abort) begin
      result_x <= dp_x_res;
      result_y <= dp_y_res;
      result_z <= dp_z_res;
    end
  end

  assign cmd_ready    = (state == S_IDLE);
  assign busy         = (state == S_LOAD) || (state == S_ITER) ||
                        (state == S_CAPTURE) || (state == S_DONE);
  assign dp_load      = (state == S_LOAD);
  assign dp_step      = (state == S_ITER);
  assign dp_iter      = (state == S_ITER) ? iter_cnt : '0;
  assign result_valid = (state == S_DONE);
  assign error        = (state == S_ERR);

endmodule
